rv32i_fetch_queue: RTL and testbench
====================================

Name: rv32i_fetch_queue

Overview:
Parametrised instruction fetch stage with a prefetch queue. It sits between instruction memory and the decode stage.
- Generates sequential fetch addresses and keeps up to DEPTH requests in flight or buffered.
- Returns instructions in order and tags each with its PC.
- Absorbs downstream stalls.
- On a redirect (branch/trap) it flushes buffered and in-flight instructions.

Parameters:
DATA_W, 32, instruction width in bits (multiple of 8)
ADDR_W, 32, fetch address / PC width
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, PC after reset

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
o_imem_req  out  1  fetch request valid
o_imem_addr  out  ADDR_W  fetch address
i_imem_stall  in  1  memory cannot accept request this cycle
i_imem_ack  in  1  response valid; responses return in request order
i_imem_inst  in  DATA_W  response data
i_flush  in  1  redirect fetch; discard everything older
i_flush_pc  in  ADDR_W  redirect target
o_inst  out  DATA_W  instruction at queue head
o_pc  out  ADDR_W  PC of o_inst
o_ce  out  1  o_inst/o_pc valid; clock enable of next stage
i_stall  in  1  next stage holds; head not consumed
o_count  out  clog2(DEPTH)+1  entries currently buffered

Behaviour:
- Reset (synchronous, while i_rst=1):
  - queue empty; req_pc = resp_pc = RESET_PC; outstanding = discard = 0.
  - o_imem_req=0, o_ce=0, o_inst=0, o_pc=0, o_count=0.
  - Reset mid-operation drops all state; acks arriving while i_rst=1 are ignored.
- STEP = DATA_W/8. All PC increments wrap modulo 2^ADDR_W. The low clog2(STEP) bits of i_flush_pc are forced to 0.
- Request issue:
  - o_imem_req = !i_rst && !i_flush && (count + outstanding - discard < DEPTH).
  - o_imem_addr = req_pc.
  - Accept = o_imem_req && !i_imem_stall. On accept: req_pc += STEP, outstanding += 1.
- Response:
  - On i_imem_ack: outstanding -= 1.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise push {i_imem_inst, resp_pc}, then resp_pc += STEP.
  - Credit check guarantees a push never overflows. An ack with outstanding == 0 is a protocol error and is ignored.
  - Accept and ack in the same cycle: net outstanding unchanged.
- Output:
  - o_ce = (count != 0) && !i_flush.
  - o_inst/o_pc = head entry when o_ce, else 0.
  - Pop when o_ce && !i_stall. While stalled, o_inst/o_pc are held stable.
  - Push and pop in the same cycle: count unchanged, allowed when full.
- Latency: ack at cycle N -> o_ce=1 at N+1 (queue was empty). Steady state with a 1-cycle-ack memory: 1 instruction/cycle.
- Flush (i_flush=1), effective at the next edge:
  - queue cleared (count=0).
  - req_pc = resp_pc = i_flush_pc.
  - discard = outstanding - (i_imem_ack ? 1 : 0). That cycle's ack is dropped.
  - No request is issued and no pop occurs in the flush cycle.
- Flush takes priority over push/pop/accept in the same cycle. Back-to-back flushes: the last target wins and discard is recomputed each cycle.
- Pointers are clog2(DEPTH) bits and wrap naturally. count ranges 0..DEPTH.

Optional Feature:
Macro FETCH_BYPASS_EN.
- Defined:
  - When count==0, discard==0, !i_flush and i_imem_ack, the response is presented combinationally the same cycle: o_ce=1, o_inst=i_imem_inst, o_pc=resp_pc.
  - If !i_stall the instruction is consumed without being written to the queue. Otherwise it is pushed normally.
  - Ack-to-o_ce latency is 0.
- Undefined: no combinational path from i_imem_* to o_*; latency 1 as above.

Test Plan:
1. Reset then release, memory acks 1 cycle after each accept, i_stall=0 -> o_imem_addr 0,4,8,...; o_ce from cycle 2 onward with o_pc 0,4,8 in order, o_inst matching memory.
2. DEPTH=4, i_stall=1 continuously -> exactly 4 requests accepted, o_count reaches 4, o_imem_req=0 thereafter. Release stall -> 4 pops in order (PCs 0..12), then fetching resumes at 0x10.
3. Memory with 3-cycle ack latency, flush to 0x100 while 2 requests are outstanding -> both late acks dropped, next o_ce shows o_pc=0x100; o_pc 0x0/0x4 never appear after the flush.
4. Flush in the same cycle as an ack and a pop, i_flush_pc=0x203 -> o_ce=0 that cycle, o_count=0 next cycle, next fetch address 0x200.
5. i_imem_stall=1 for 5 cycles mid-stream -> o_imem_addr held constant, req_pc not advanced, no duplicate or missing PCs after release.
6. FETCH_BYPASS_EN defined, empty queue, ack of 0x00000013 with i_stall=0 -> o_ce=1 and o_inst=0x00000013 in the ack cycle, o_count stays 0. Not defined: the same instruction appears one cycle later with o_count=1 for one cycle.

Source files
------------

// File: rtl/rv32i_fetch_queue.sv
// rtl/rv32i_fetch_queue.sv - RV32I instruction fetch stage with in-order prefetch queue
//
// Issues sequential fetch requests to instruction memory and keeps up to DEPTH
// instructions either in flight or buffered. Returns instructions to decode in
// order, each tagged with its PC. A redirect (i_flush) empties the queue and
// marks every in-flight response for discard.
//
// Optional build macro: FETCH_BYPASS_EN. When defined, a response that arrives
// while the queue is empty and nothing is being discarded is presented to
// decode in the same cycle (ack-to-o_ce latency 0). When undefined, o_* are
// driven only from registered state (latency 1).
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   o_imem_req, o_imem_addr   fetch request and its address
//   i_imem_stall              memory refuses the request this cycle
//   i_imem_ack, i_imem_inst   in-order response strobe and data
//   i_flush, i_flush_pc       redirect fetch to a new target
//   o_inst, o_pc, o_ce        head instruction, its PC, valid / next-stage enable
//   i_stall                   next stage holds, head is not consumed
//   o_count                   number of buffered entries

module rv32i_fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    output logic                       o_imem_req,
    output logic [ADDR_W-1:0]          o_imem_addr,
    input  logic                       i_imem_stall,
    input  logic                       i_imem_ack,
    input  logic [DATA_W-1:0]          i_imem_inst,
    input  logic                       i_flush,
    input  logic [ADDR_W-1:0]          i_flush_pc,
    output logic [DATA_W-1:0]          o_inst,
    output logic [ADDR_W-1:0]          o_pc,
    output logic                       o_ce,
    input  logic                       i_stall,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Repeated flushes without acks let outstanding exceed DEPTH (old requests
    // still owed by memory plus new ones), so give it headroom.
    localparam int OW = CW + 3;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    logic [DATA_W-1:0] mem_inst_q [DEPTH];
    logic [DATA_W-1:0] mem_inst_d [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
    logic [ADDR_W-1:0] mem_pc_d   [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic [OW-1:0]     discard_q, discard_d;

    logic              ack_ok;
    logic              accept;
    logic              head_valid;
    logic              keep_data;
    logic              bypass;
    logic              push;
    logic              pop;
    logic [OW-1:0]     credit_used;

    always_comb begin
        // An ack with nothing outstanding is a memory protocol error; ignore it.
        ack_ok      = i_imem_ack && (outstanding_q != '0);
        head_valid  = (count_q != '0);
        // Requests already charged to a discard will never occupy the queue.
        credit_used = OW'(count_q) + outstanding_q - discard_q;

        o_imem_req  = !i_rst && !i_flush && (credit_used < OW'(DEPTH));
        o_imem_addr = req_pc_q;
        accept      = o_imem_req && !i_imem_stall;

        keep_data   = ack_ok && (discard_q == '0) && !i_flush && !i_rst;

`ifdef FETCH_BYPASS_EN
        bypass = keep_data && !head_valid;
        o_ce   = (head_valid && !i_flush && !i_rst) || bypass;
        if (bypass) begin
            o_inst = i_imem_inst;
            o_pc   = resp_pc_q;
        end else if (o_ce) begin
            o_inst = mem_inst_q[rd_ptr_q];
            o_pc   = mem_pc_q[rd_ptr_q];
        end else begin
            o_inst = '0;
            o_pc   = '0;
        end
`else
        bypass = 1'b0;
        o_ce   = head_valid && !i_flush && !i_rst;
        o_inst = o_ce ? mem_inst_q[rd_ptr_q] : '0;
        o_pc   = o_ce ? mem_pc_q[rd_ptr_q]   : '0;
`endif

        // A bypassed instruction consumed this cycle never enters the queue.
        push = keep_data && !(bypass && !i_stall);
        pop  = head_valid && o_ce && !i_stall;

        o_count = count_q;
    end

    always_comb begin
        mem_inst_d    = mem_inst_q;
        mem_pc_d      = mem_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        req_pc_d      = req_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (i_flush) begin
            // Everything still owed by memory after this cycle's ack is stale.
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            req_pc_d      = i_flush_pc & ~(STEP - ADDR_W'(1));
            resp_pc_d     = i_flush_pc & ~(STEP - ADDR_W'(1));
            outstanding_d = outstanding_q - OW'(ack_ok);
            discard_d     = outstanding_q - OW'(ack_ok);
        end else begin
            if (accept) begin
                req_pc_d = req_pc_q + STEP;
            end
            outstanding_d = outstanding_q + OW'(accept) - OW'(ack_ok);
            if (ack_ok) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - OW'(1);
                end else begin
                    resp_pc_d = resp_pc_q + STEP;
                end
            end
            if (push) begin
                mem_inst_d[wr_ptr_q] = i_imem_inst;
                mem_pc_d[wr_ptr_q]   = resp_pc_q;
                wr_ptr_d             = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_inst_q    <= '{default: '0};
            mem_pc_q      <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            req_pc_q      <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            mem_inst_q    <= mem_inst_d;
            mem_pc_q      <= mem_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            req_pc_q      <= req_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// tb/tb_rv32i_fetch_queue.sv - directed self-checking bench for rv32i_fetch_queue

module tb_rv32i_fetch_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

`ifdef FETCH_BYPASS_EN
    localparam int FIRST_CE = 1;
    localparam int T3_CE    = 6;
    localparam logic [31:0] T4_END = 32'h214;
    localparam logic [31:0] T5_END = 32'h38;
`else
    localparam int FIRST_CE = 2;
    localparam int T3_CE    = 7;
    localparam logic [31:0] T4_END = 32'h210;
    localparam logic [31:0] T5_END = 32'h34;
`endif

    logic              clk = 1'b0;
    logic              i_rst;
    logic              o_imem_req;
    logic [ADDR_W-1:0] o_imem_addr;
    logic              i_imem_stall;
    logic              i_imem_ack;
    logic [DATA_W-1:0] i_imem_inst;
    logic              i_flush;
    logic [ADDR_W-1:0] i_flush_pc;
    logic [DATA_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_pc;
    logic              o_ce;
    logic              i_stall;
    logic [$clog2(DEPTH):0] o_count;

    rv32i_fetch_queue #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_stall (i_imem_stall),
        .i_imem_ack   (i_imem_ack),
        .i_imem_inst  (i_imem_inst),
        .i_flush      (i_flush),
        .i_flush_pc   (i_flush_pc),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_ce         (o_ce),
        .i_stall      (i_stall),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cycle;
    int          lat;
    bit          mem_en;
    bit          mon_en;
    int          acc_cnt;
    logic [31:0] exp_pc;
    logic [31:0] hold_addr;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // In-order memory: each accepted request is acked 'lat' cycles later.
    task automatic drive_mem();
        logic [31:0] a;
        int          d;
        i_imem_ack  = 1'b0;
        i_imem_inst = '0;
        if (mem_en && pend_addr.size() > 0 && pend_due[0] <= cycle) begin
            a = pend_addr.pop_front();
            d = pend_due.pop_front();
            i_imem_ack  = 1'b1;
            i_imem_inst = mem_data(a);
        end
    endtask

    // Observe consumption and request acceptance at the end of the cycle, then advance.
    task automatic next_cycle();
        if (mon_en && o_ce && !i_stall) begin
            chk("pc_order", o_pc, exp_pc);
            chk("inst_data", o_inst, mem_data(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        if (!i_rst && o_imem_req && !i_imem_stall) begin
            acc_cnt++;
            if (mem_en) begin
                pend_addr.push_back(o_imem_addr);
                pend_due.push_back(cycle + lat);
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        drive_mem();
        #1;
    endtask

    task automatic do_reset();
        i_rst        = 1'b1;
        i_imem_stall = 1'b0;
        i_imem_ack   = 1'b0;
        i_imem_inst  = '0;
        i_flush      = 1'b0;
        i_flush_pc   = '0;
        i_stall      = 1'b0;
        mem_en       = 1'b1;
        mon_en       = 1'b0;
        lat          = 1;
        pend_addr.delete();
        pend_due.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_ce", 32'(o_ce), 32'd0);
        chk("rst_inst", o_inst, 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        i_rst   = 1'b0;
        cycle   = 0;
        acc_cnt = 0;
        drive_mem();
        #1;
    endtask

    initial begin
        // 1: streaming with 1-cycle ack
        do_reset();
        mon_en = 1'b1;
        exp_pc = 32'h0;
        for (int c = 0; c < 8; c++) begin
            chk("t1_req", 32'(o_imem_req), 32'd1);
            chk("t1_addr", o_imem_addr, 32'(4 * c));
            chk("t1_ce", 32'(o_ce), 32'(c >= FIRST_CE));
            next_cycle();
        end

        // 2: downstream stall fills the queue, then drains in order
        do_reset();
        i_stall = 1'b1;
        mon_en  = 1'b1;
        exp_pc  = 32'h0;
        repeat (8) next_cycle();
        chk("t2_accepts", 32'(acc_cnt), 32'd4);
        chk("t2_count_full", 32'(o_count), 32'd4);
        chk("t2_req_blocked", 32'(o_imem_req), 32'd0);
        chk("t2_head_pc", o_pc, 32'h0);
        i_stall = 1'b0;
        #1;
        next_cycle();
        chk("t2_resume_req", 32'(o_imem_req), 32'd1);
        chk("t2_resume_addr", o_imem_addr, 32'h10);
        repeat (10) next_cycle();
        chk("t2_consumed", exp_pc, 32'h2C);

        // 3: flush with two late responses outstanding
        do_reset();
        lat = 3;
        next_cycle();
        next_cycle();
        i_flush    = 1'b1;
        i_flush_pc = 32'h100;
        #1;
        chk("t3_flush_req", 32'(o_imem_req), 32'd0);
        chk("t3_flush_ce", 32'(o_ce), 32'd0);
        next_cycle();
        i_flush = 1'b0;
        #1;
        chk("t3_addr", o_imem_addr, 32'h100);
        chk("t3_count", 32'(o_count), 32'd0);
        for (int k = 0; k < 20 && !o_ce; k++) next_cycle();
        chk("t3_ce_seen", 32'(o_ce), 32'd1);
        chk("t3_ce_cycle", 32'(cycle), 32'(T3_CE));
        mon_en = 1'b1;
        exp_pc = 32'h100;
        repeat (6) next_cycle();

        // 4: flush coinciding with ack and pop, misaligned target
        do_reset();
        mon_en = 1'b1;
        exp_pc = 32'h0;
        repeat (4) next_cycle();
        chk("t4_pre_ack", 32'(i_imem_ack), 32'd1);
        i_flush    = 1'b1;
        i_flush_pc = 32'h203;
        #1;
        chk("t4_flush_ce", 32'(o_ce), 32'd0);
        chk("t4_flush_req", 32'(o_imem_req), 32'd0);
        next_cycle();
        i_flush = 1'b0;
        #1;
        chk("t4_count", 32'(o_count), 32'd0);
        chk("t4_ce_after", 32'(o_ce), 32'd0);
        chk("t4_addr", o_imem_addr, 32'h200);
        exp_pc = 32'h200;
        repeat (6) next_cycle();
        chk("t4_consumed", exp_pc, T4_END);

        // 5: memory stall mid-stream
        do_reset();
        mon_en = 1'b1;
        exp_pc = 32'h0;
        repeat (5) next_cycle();
        i_imem_stall = 1'b1;
        #1;
        hold_addr = 32'h14;
        repeat (5) begin
            chk("t5_addr_held", o_imem_addr, hold_addr);
            next_cycle();
        end
        i_imem_stall = 1'b0;
        #1;
        chk("t5_addr_release", o_imem_addr, 32'h14);
        repeat (10) next_cycle();
        chk("t5_consumed", exp_pc, T5_END);

        // 6: spurious ack ignored, then single-instruction latency
        do_reset();
        mem_en       = 1'b0;
        i_imem_stall = 1'b1;
        i_imem_ack   = 1'b1;
        i_imem_inst  = 32'hDEAD_BEEF;
        #1;
        chk("t6_spur_ce", 32'(o_ce), 32'd0);
        next_cycle();
        chk("t6_spur_count", 32'(o_count), 32'd0);
        i_imem_stall = 1'b0;
        #1;
        chk("t6_req", 32'(o_imem_req), 32'd1);
        chk("t6_addr", o_imem_addr, 32'h0);
        next_cycle();
        i_imem_stall = 1'b1;
        i_imem_ack   = 1'b1;
        i_imem_inst  = 32'h0000_0013;
        #1;
`ifdef FETCH_BYPASS_EN
        chk("t6_ack_ce", 32'(o_ce), 32'd1);
        chk("t6_ack_inst", o_inst, 32'h13);
        chk("t6_ack_pc", o_pc, 32'h0);
        chk("t6_ack_count", 32'(o_count), 32'd0);
        next_cycle();
        chk("t6_next_ce", 32'(o_ce), 32'd0);
        chk("t6_next_count", 32'(o_count), 32'd0);
`else
        chk("t6_ack_ce", 32'(o_ce), 32'd0);
        chk("t6_ack_count", 32'(o_count), 32'd0);
        next_cycle();
        chk("t6_next_ce", 32'(o_ce), 32'd1);
        chk("t6_next_inst", o_inst, 32'h13);
        chk("t6_next_pc", o_pc, 32'h0);
        chk("t6_next_count", 32'(o_count), 32'd1);
        next_cycle();
        chk("t6_drain_count", 32'(o_count), 32'd0);
        chk("t6_drain_ce", 32'(o_ce), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
